// File: rtl/hbm_delay_release_sched.sv
// hbm_delay_release_sched
// Release scheduler for the HBM latency-emulation path. It owns the free-running
// delay timer, picks one delay FIFO whose header flit has expired (round-robin
// among eligible FIFOs) and drains that whole packet onto the single NoC output.
// Optional statistics outputs are enabled with the macro HBM_DELAY_STATS_EN.
module hbm_delay_release_sched #(
    parameter int FIFO_NUM       = 2,
    parameter int NOC_DATA_WIDTH = 64,
    parameter int TIMERw         = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [TIMERw-1:0]                  timer_o,
    input  logic [FIFO_NUM-1:0]                fifo_valid_i,
    input  logic [FIFO_NUM*NOC_DATA_WIDTH-1:0] fifo_flit_i,
    input  logic [FIFO_NUM-1:0]                fifo_head_i,
    input  logic [FIFO_NUM-1:0]                fifo_tail_i,
    input  logic [FIFO_NUM*TIMERw-1:0]         fifo_exp_time_i,
    output logic [FIFO_NUM-1:0]                fifo_rd_o,
    output logic                               noc_valid_o,
    output logic [NOC_DATA_WIDTH-1:0]          noc_data_o,
    input  logic                               noc_ready_i,
    output logic                               proto_err_o
`ifdef HBM_DELAY_STATS_EN
    ,
    output logic [31:0]                        pkt_cnt_o,
    output logic [TIMERw-1:0]                  max_late_o
`endif
);

    localparam int PW = (FIFO_NUM > 1) ? $clog2(FIFO_NUM) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Wrap-safe expiry: the head is due once (now - exp_time) is non-negative
    // when read as a signed TIMERw-bit number.
    function automatic logic is_expired(input logic [TIMERw-1:0] now,
                                        input logic [TIMERw-1:0] exp_time);
        logic [TIMERw-1:0] diff;
        diff = now - exp_time;
        return ~diff[TIMERw-1];
    endfunction

    state_t                    state_r, state_nxt_s;
    logic [PW-1:0]             grant_r, grant_nxt_s;
    logic [PW-1:0]             rr_ptr_r, rr_ptr_nxt_s;
    logic                      first_beat_r, first_beat_nxt_s;
    logic [TIMERw-1:0]         timer_r;
    logic                      proto_err_r;
    logic                      err_set_s;
    logic [FIFO_NUM-1:0]       expired_s;
    logic [FIFO_NUM-1:0]       eligible_s;
    logic                      pick_found_s;
    logic [PW-1:0]             pick_idx_s;
    logic                      cur_valid_s;
    logic                      cur_head_s;
    logic                      cur_tail_s;
    logic [NOC_DATA_WIDTH-1:0] cur_flit_s;
    logic                      accept_s;

    // Expiry flag of every FIFO head against the current timer
    always_comb begin
        expired_s = '0;
        for (int i = 0; i < FIFO_NUM; i++) begin
            expired_s[i] = is_expired(timer_r, fifo_exp_time_i[i*TIMERw +: TIMERw]);
        end
    end

    // A FIFO whose head is not a header is never eligible
    assign eligible_s = fifo_valid_i & fifo_head_i & expired_s;

    // Round-robin pick: first eligible at or above rr_ptr, else lowest eligible
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 0; i < FIFO_NUM; i++) begin
            if (!pick_found_s && eligible_s[i] && (PW'(i) >= rr_ptr_r)) begin
                pick_found_s = 1'b1;
                pick_idx_s   = PW'(i);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
        for (int i = 0; i < FIFO_NUM; i++) begin
            if (!pick_found_s && eligible_s[i]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = PW'(i);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Head entry of the granted FIFO
    always_comb begin
        cur_valid_s = 1'b0;
        cur_head_s  = 1'b0;
        cur_tail_s  = 1'b0;
        cur_flit_s  = '0;
        for (int i = 0; i < FIFO_NUM; i++) begin
            if (grant_r == PW'(i)) begin
                cur_valid_s = fifo_valid_i[i];
                cur_head_s  = fifo_head_i[i];
                cur_tail_s  = fifo_tail_i[i];
                cur_flit_s  = fifo_flit_i[i*NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
            end else begin
                cur_valid_s = cur_valid_s;
            end
        end
    end

    assign accept_s = (state_r == BURST) & cur_valid_s & noc_ready_i;

    // Framing errors: stray body flit while idle, or a header mid-burst
    always_comb begin
        if (state_r == IDLE) begin
            err_set_s = |(fifo_valid_i & ~fifo_head_i);
        end else begin
            err_set_s = cur_valid_s & cur_head_s & ~first_beat_r;
        end
    end

    // Next-state and NoC/pop outputs of the release FSM
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        first_beat_nxt_s = first_beat_r;
        noc_valid_o      = 1'b0;
        noc_data_o       = '0;
        fifo_rd_o        = '0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s      = BURST;
                    grant_nxt_s      = pick_idx_s;
                    first_beat_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                noc_valid_o = cur_valid_s;
                noc_data_o  = cur_valid_s ? cur_flit_s : '0;
                for (int i = 0; i < FIFO_NUM; i++) begin
                    fifo_rd_o[i] = accept_s & (grant_r == PW'(i));
                end
                if (accept_s) begin
                    first_beat_nxt_s = 1'b0;
                    if (cur_tail_s) begin
                        state_nxt_s  = IDLE;
                        rr_ptr_nxt_s = (grant_r == PW'(FIFO_NUM - 1)) ? PW'(0)
                                                                      : grant_r + PW'(1);
                    end else begin
                        state_nxt_s = BURST;
                    end
                end else begin
                    state_nxt_s = BURST;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, timer and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            rr_ptr_r     <= '0;
            first_beat_r <= 1'b0;
            timer_r      <= '0;
            proto_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            first_beat_r <= first_beat_nxt_s;
            timer_r      <= timer_r + TIMERw'(1);
            proto_err_r  <= proto_err_r | err_set_s;
        end
    end

    assign timer_o     = timer_r;
    assign proto_err_o = proto_err_r;

`ifdef HBM_DELAY_STATS_EN
    logic [31:0]       pkt_cnt_r;
    logic [TIMERw-1:0] max_late_r;
    logic [TIMERw-1:0] pick_exp_s;
    logic [TIMERw-1:0] late_s;

    // Lateness of the header being selected this cycle
    always_comb begin
        pick_exp_s = '0;
        for (int i = 0; i < FIFO_NUM; i++) begin
            if (pick_idx_s == PW'(i)) begin
                pick_exp_s = fifo_exp_time_i[i*TIMERw +: TIMERw];
            end else begin
                pick_exp_s = pick_exp_s;
            end
        end
        late_s = timer_r - pick_exp_s;
    end

    // Saturating packet count and maximum release lateness
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_r  <= 32'd0;
            max_late_r <= '0;
        end else begin
            if (accept_s && cur_tail_s && (pkt_cnt_r != 32'hFFFF_FFFF)) begin
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
            if ((state_r == IDLE) && pick_found_s && (late_s > max_late_r)) begin
                max_late_r <= late_s;
            end else begin
                max_late_r <= max_late_r;
            end
        end
    end

    assign pkt_cnt_o  = pkt_cnt_r;
    assign max_late_o = max_late_r;
`endif

endmodule
